// File: rtl/sram_arbiter.sv
// Arbiter and access sequencer for the shared 1M x 16 audio SRAM.
// It serves the playback read port and the recorder write port, with read priority limited by a streak count.
module sram_arbiter #(
    parameter int READ_WAIT     = 2,
    parameter int WR_PULSE      = 2,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rd_req,
    input  logic [19:0] i_rd_addr,
    output logic        o_rd_ack,
    output logic [15:0] o_rd_data,
    input  logic        i_wr_req,
    input  logic [19:0] i_wr_addr,
    input  logic [15:0] i_wr_data,
    output logic        o_wr_ack,
    output logic        o_busy,
    output logic [19:0] o_sram_addr,
    inout  wire  [15:0] io_sram_dq,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    output logic        o_sram_lb_n,
    output logic        o_sram_ub_n
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_RACK  = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_WHOLD = 3'd4;
    localparam logic [2:0] S_TURN  = 3'd5;

    localparam logic [2:0] RD_LAST    = 3'(READ_WAIT - 1);
    localparam logic [2:0] WR_LAST    = 3'(WR_PULSE - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_RD_STREAK);

    logic [2:0]  state;
    logic [2:0]  wait_cnt;
    logic [3:0]  streak;
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        rd_grant;
    logic        wr_grant;
    logic        active;
    logic        dq_drive;

    // A pending write overrides read priority once reads have won MAX_RD_STREAK times in a row.
    always_comb begin
        rd_grant = i_rd_req && !(i_wr_req && (streak == STREAK_MAX));
        wr_grant = i_wr_req && !rd_grant;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            streak   <= 4'd0;
            addr_q   <= 20'd0;
            wdata_q  <= 16'd0;
            rdata_q  <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= 3'd0;
                    if (!i_wr_req || wr_grant) begin
                        streak <= 4'd0;
                    end else if (rd_grant) begin
                        streak <= streak + 4'd1;
                    end
                    if (rd_grant) begin
                        state  <= S_RD;
                        addr_q <= i_rd_addr;
                    end else if (wr_grant) begin
                        state   <= S_WR;
                        addr_q  <= i_wr_addr;
                        wdata_q <= i_wr_data;
                    end
                end
                S_RD: begin
                    if (wait_cnt == RD_LAST) begin
                        rdata_q <= io_sram_dq;
                        state   <= S_RACK;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_RACK:  state <= S_IDLE;
                S_WR: begin
                    if (wait_cnt == WR_LAST) begin
                        state <= S_WHOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_WHOLD: state <= S_TURN;
                S_TURN:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pins decode from registered state only, so reset forces WE_N high and releases dq immediately.
    always_comb begin
        active   = (state == S_RD) || (state == S_WR) || (state == S_WHOLD);
        dq_drive = (state == S_WR) || (state == S_WHOLD);
    end

    assign o_busy      = (state != S_IDLE);
    assign o_rd_ack    = (state == S_RACK);
    assign o_wr_ack    = (state == S_TURN);
    assign o_rd_data   = rdata_q;
    assign o_sram_addr = addr_q;
    assign o_sram_ce_n = !active;
    assign o_sram_oe_n = (state != S_RD);
    assign o_sram_we_n = (state != S_WR);
    assign o_sram_lb_n = !active;
    assign o_sram_ub_n = !active;
    assign io_sram_dq  = dq_drive ? wdata_q : 16'hzzzz;

endmodule
